// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used across pipeline stages.
// Holds reset PC default, opcode constants and fetch bundle type.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_NOP     = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Instruction word paired with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Targets are always word aligned in this core.
  function automatic logic [XLEN-1:0] align_pc(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO buffering fetched words ahead of decode.
// Flush empties it in one edge; head reads as zero when empty.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~w_full | w_pop);
  assign o_count = r_count;
  assign o_dout  = o_empty ? '0 : r_mem[r_rd];

  // Pointer and occupancy tracking; flush and reset clear both.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= inc(r_wr);
      if (w_pop)  r_rd <= inc(r_rd);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage write; contents need no reset since head is gated by count.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush && !i_rst) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem issue, kill of stale returns.
// Returned words queue in fetch_fifo and go to decode on valid/ready.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          IMEM_AW   = 12,
  parameter int          BUF_DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_dec_ready,
  input  logic               i_redirect_valid,
  input  logic [31:0]        i_redirect_pc,
  output logic               o_imem_en,
  output logic [IMEM_AW-1:0] o_imem_addr,
  input  logic [31:0]        i_imem_dout,
  output logic               o_inst_valid,
  output logic [31:0]        o_inst,
  output logic [31:0]        o_inst_pc
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [31:0]  r_pc;
  logic [31:0]  r_tag;
  logic         r_inflight;
  logic         r_kill;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_occ;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  fetch_entry_t  w_in;
  fetch_entry_t  w_head;

  // Space check counts the word already in flight toward the buffer.
  always_comb begin
    w_pop   = o_inst_valid & i_dec_ready;
    w_occ   = {1'b0, w_count}
            + (CW+1)'(r_inflight)
            - (CW+1)'(w_pop);
    w_issue = ~i_rst & ~i_redirect_valid
            & (w_occ < (CW+1)'(BUF_DEPTH));
    w_push  = r_inflight & ~r_kill & ~i_redirect_valid;
    w_in.inst = i_imem_dout;
    w_in.pc   = r_tag;
  end

  assign o_imem_en    = w_issue;
  assign o_imem_addr  = r_pc[IMEM_AW+1:2];
  assign o_inst_valid = ~w_empty;
  assign o_inst       = w_head.inst;
  assign o_inst_pc    = w_head.pc;

  // PC advance, redirect load, and in-flight/kill bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc       <= RESET_PC;
      r_tag      <= '0;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_kill     <= i_redirect_valid;
      if (i_redirect_valid) begin
        r_pc <= align_pc(i_redirect_pc);
      end else if (w_issue) begin
        r_pc  <= r_pc + 32'd4;
        r_tag <= r_pc;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (64),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_redirect_valid),
    .i_push  (w_push),
    .i_din   (w_in),
    .i_pop   (w_pop),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_dout  (w_head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table for start-up, scripted
// sequences for stall/redirect/reset, scoreboard of expected PCs.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        redir = 1'b0;
  logic [31:0] rpc = '0;
  logic        redir2 = 1'b0;
  logic [31:0] rpc2 = '0;

  logic        en1, en2;
  logic [11:0] addr1, addr2;
  logic [31:0] dout1 = '0, dout2 = '0;
  logic        vld1, vld2;
  logic [31:0] inst1, inst2, pc1, pc2;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk(clk), .i_rst(rst), .i_dec_ready(rdy),
    .i_redirect_valid(redir), .i_redirect_pc(rpc),
    .o_imem_en(en1), .o_imem_addr(addr1),
    .i_imem_dout(dout1), .o_inst_valid(vld1),
    .o_inst(inst1), .o_inst_pc(pc1)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_dec_ready(rdy),
    .i_redirect_valid(redir2), .i_redirect_pc(rpc2),
    .o_imem_en(en2), .o_imem_addr(addr2),
    .i_imem_dout(dout2), .o_inst_valid(vld2),
    .o_inst(inst2), .o_inst_pc(pc2)
  );

  function automatic logic [31:0] word(input logic [11:0] a);
    return 32'h1000_0000 + {20'h0, a};
  endfunction

  // synchronous imem models, one-cycle latency
  always @(posedge clk) begin
    if (en1) dout1 <= word(addr1);
    if (en2) dout2 <= word(addr2);
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", n, act, exp);
    end
  endtask

  // scoreboard of PCs the decode side must see, in order
  logic [31:0] sb_q[$];
  logic        prev_hold = 1'b0;
  logic [31:0] prev_inst, prev_pc;

  task automatic sb_fill(input logic [31:0] start);
    sb_q.delete();
    for (int k = 0; k < 200; k++) sb_q.push_back(start + 32'(4 * k));
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      if (prev_hold) begin
        chk("hold_valid", {31'b0, vld1}, 32'd1);
        chk("hold_inst", inst1, prev_inst);
        chk("hold_pc", pc1, prev_pc);
      end
      if (vld1 && rdy) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_pc", pc1, e);
          chk("sb_inst", inst1, word(e[13:2]));
        end
      end
    end
    prev_hold = !rst && !redir && vld1 && !rdy;
    prev_inst = inst1;
    prev_pc   = pc1;
    if (rst) sb_fill(32'h0);
    else if (redir) sb_fill({rpc[31:2], 2'b00});
  end

  task automatic drive(input logic r, input logic d,
                       input logic rv, input logic [31:0] rp);
    @(posedge clk);
    #1;
    rst = r; rdy = d; redir = rv; rpc = rp;
    @(negedge clk);
  endtask

  task automatic exp1(input string n, input logic en,
                      input logic [11:0] a, input logic v,
                      input logic [31:0] pc);
    chk({n, "_en"}, {31'b0, en1}, {31'b0, en});
    if (en) chk({n, "_addr"}, {20'b0, addr1}, {20'b0, a});
    chk({n, "_vld"}, {31'b0, vld1}, {31'b0, v});
    chk({n, "_pc"}, pc1, v ? pc : 32'h0);
    chk({n, "_inst"}, inst1, v ? word(pc[13:2]) : 32'h0);
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        en;
    logic [11:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic        vld2;
    logic [31:0] pc2;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1, 1, 0, 12'h0, 0, 32'h0, 0, 32'h0};
    tbl[1] = '{1, 1, 0, 12'h0, 0, 32'h0, 0, 32'h0};
    tbl[2] = '{1, 1, 0, 12'h0, 0, 32'h0, 0, 32'h0};
    tbl[3] = '{0, 1, 1, 12'h0, 0, 32'h0, 0, 32'h0};
    tbl[4] = '{0, 1, 1, 12'h1, 0, 32'h0, 0, 32'h0};
    tbl[5] = '{0, 1, 1, 12'h2, 1, 32'h0, 1, 32'hFFFF_FFF8};
    tbl[6] = '{0, 1, 1, 12'h3, 1, 32'h4, 1, 32'hFFFF_FFFC};
    tbl[7] = '{0, 1, 1, 12'h4, 1, 32'h8, 1, 32'h0000_0000};
    tbl[8] = '{0, 1, 1, 12'h5, 1, 32'hC, 1, 32'h0000_0004};

    // reset release, latency, streaming; second DUT wraps PC
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].rst, tbl[i].rdy, 1'b0, 32'h0);
      exp1($sformatf("t1[%0d]", i), tbl[i].en, tbl[i].addr,
           tbl[i].vld, tbl[i].pc);
      chk($sformatf("t5_vld[%0d]", i), {31'b0, vld2},
          {31'b0, tbl[i].vld2});
      chk($sformatf("t5_pc[%0d]", i), pc2,
          tbl[i].vld2 ? tbl[i].pc2 : 32'h0);
      chk($sformatf("t5_inst[%0d]", i), inst2,
          tbl[i].vld2 ? word(tbl[i].pc2[13:2]) : 32'h0);
    end

    // backpressure: issue stops once buffer plus in-flight is full
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      chk($sformatf("t2_en_stall[%0d]", i), {31'b0, en1}, 32'd0);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t2_en_resume", {31'b0, en1}, 32'd1);
    chk("t2_addr_resume", {20'b0, addr1}, 32'h6);
    repeat (6) drive(1'b0, 1'b1, 1'b0, 32'h0);

    // redirect with a word in flight and a pop in the same cycle
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0103);
    chk("t3_en_redir", {31'b0, en1}, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    exp1("t3_r1", 1'b1, 12'h40, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    exp1("t3_r2", 1'b1, 12'h41, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    exp1("t3_r3", 1'b1, 12'h42, 1'b1, 32'h100);
    repeat (4) drive(1'b0, 1'b1, 1'b0, 32'h0);

    // back-to-back redirects: the later target wins
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0200);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0302);
    chk("t4_en_redir2", {31'b0, en1}, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    exp1("t4_r1", 1'b1, 12'hC0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    exp1("t4_r2", 1'b1, 12'hC1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    exp1("t4_r3", 1'b1, 12'hC2, 1'b1, 32'h300);
    repeat (3) drive(1'b0, 1'b1, 1'b0, 32'h0);

    // redirect during a stall: nothing stale survives
    repeat (3) drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0400);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    exp1("t4s_r1", 1'b1, 12'h100, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    exp1("t4s_r3", 1'b0, 12'h0, 1'b1, 32'h400);
    repeat (5) drive(1'b0, 1'b1, 1'b0, 32'h0);

    // reset with a full buffer: clean restart at RESET_PC
    repeat (3) drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t6_en_rst", {31'b0, en1}, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    exp1("t6_r1", 1'b1, 12'h0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    exp1("t6_r2", 1'b1, 12'h1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    exp1("t6_r3", 1'b1, 12'h2, 1'b1, 32'h0);
    chk("t6_pc2", pc2, 32'hFFFF_FFF8);
    repeat (4) drive(1'b0, 1'b1, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
